// File: rtl/spu_lsurpt_pkg.sv
// Shared constants, types and helpers for the SPU<->LSU repeater/staging block.
// The PCX address field positions below are bit positions inside the request packet.
package spu_lsurpt_pkg;

  localparam int ADDR_HI     = 103;
  localparam int ADDR_LO     = 64;
  localparam int ERR_ADDR_W  = 36;
  localparam int LDXA_DATA_W = 64;
  localparam int LDXA_TID_W  = 2;

  // Default-configuration layout of one LDXA return entry (MSB first).
  typedef struct packed {
    logic [LDXA_DATA_W-1:0] data;
    logic [LDXA_TID_W-1:0]  tid;
    logic                   illgl_va;
  } ldxa_entry_t;

  function automatic int tid_width(input int nthr);
    return (nthr > 1) ? $clog2(nthr) : 1;
  endfunction

endpackage

// File: rtl/spu_lsurpt_fifo.sv
// Generic DEPTH x W synchronous FIFO with a registered head, registered full/valid flags
// and a sticky overflow flag used only by an assertion.
module spu_lsurpt_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic         full,
  output logic [W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic          vld_reg, full_reg, ovf_reg;
  logic          pop, push_ok;

  assign pop     = vld_reg & rdy;
  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign push_ok = push & (~full_reg | pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      vld_reg    <= 1'b0;
      full_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      vld_reg   <= (count_next != '0);
      full_reg  <= (count_next == (PW+1)'(DEPTH));
      if (push & full_reg & ~pop) ovf_reg <= 1'b1;
    end
  end

  ovf_never : assert property (@(posedge clk) disable iff (rst) !ovf_reg);

  assign vld  = vld_reg;
  assign full = full_reg;
  assign dout = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/spu_lsurpt_gen.sv
// SPU<->LSU repeater: PCX packet register with bank-select bypass, rs3 store-data
// pipeline with flush, LDXA return FIFO, store-buffer-empty and error-address staging.
module spu_lsurpt_gen
  import spu_lsurpt_pkg::*;
#(
  parameter int  PCX_W      = 123,
  parameter int  BSEL_LO    = 70,
  parameter int  DATA_W     = 64,
  parameter int  RS3_STAGES = 3,
  parameter int  NTHR       = 4,
  parameter int  LDXA_DEPTH = 2,
  localparam int TID_W      = tid_width(NTHR)
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic [PCX_W-1:0]      spu_pcx_pkt,
  input  logic                  spu_pcx_wen,
  input  logic                  spu_pcx_bsel_byp,
  output logic [PCX_W-1:0]      spu_lsu_ldst_pckt,
  input  logic                  spu_ldxa_vld,
  input  logic [DATA_W-1:0]     spu_ldxa_data,
  input  logic [TID_W-1:0]      spu_ldxa_tid,
  input  logic                  spu_ldxa_illgl_va,
  output logic                  spu_ldxa_full,
  input  logic                  lsu_ldxa_rdy,
  output logic                  spu_lsu_ldxa_vld_w2,
  output logic [DATA_W-1:0]     spu_lsu_ldxa_data_w2,
  output logic [TID_W-1:0]      spu_lsu_ldxa_tid_w2,
  output logic                  spu_lsu_ldxa_illgl_va_w2,
  input  logic [DATA_W-1:0]     exu_rs3_data_e,
  input  logic                  exu_rs3_vld_e,
  input  logic                  spu_rs3_flush,
  output logic [DATA_W-1:0]     spu_lsurpt_rs3_data,
  output logic                  spu_lsurpt_rs3_vld,
  input  logic [NTHR-1:0]       lsu_spu_stb_empty,
  output logic [NTHR-1:0]       spu_lsurpt_stb_empty,
  input  logic                  spu_unc_error_w,
  output logic                  spu_lsu_unc_error_w2,
  output logic [ERR_ADDR_W-1:0] spu_ifu_err_addr_w2
);

  localparam int ENT_W = DATA_W + TID_W + 1;

  logic [PCX_W-1:0]      pkt_reg, pkt_out;
  logic [NTHR-1:0]       stb_empty_reg;
  logic                  unc_error_reg;
  logic [ERR_ADDR_W-1:0] err_addr_reg;
  logic [ENT_W-1:0]      ldxa_head;

  always_comb begin
    pkt_out = pkt_reg;
    if (spu_pcx_bsel_byp) pkt_out[BSEL_LO +: 2] = spu_pcx_pkt[BSEL_LO +: 2];
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      pkt_reg       <= '0;
      stb_empty_reg <= '1;
      unc_error_reg <= 1'b0;
      err_addr_reg  <= '0;
    end else begin
      if (spu_pcx_wen) pkt_reg <= spu_pcx_pkt;
      stb_empty_reg <= lsu_spu_stb_empty;
      unc_error_reg <= spu_unc_error_w;
      // Captured from the visible packet so a bypassed bank select is what gets reported.
      if (spu_unc_error_w) err_addr_reg <= pkt_out[ADDR_HI:ADDR_LO+4];
    end
  end

  assign spu_lsu_ldst_pckt    = pkt_out;
  assign spu_lsurpt_stb_empty = stb_empty_reg;
  assign spu_lsu_unc_error_w2 = unc_error_reg;
  assign spu_ifu_err_addr_w2  = err_addr_reg;

  spu_lsurpt_fifo #(
    .DEPTH (LDXA_DEPTH),
    .W     (ENT_W)
  ) u_ldxa_fifo (
    .clk  (rclk),
    .rst  (reset),
    .push (spu_ldxa_vld),
    .din  ({spu_ldxa_data, spu_ldxa_tid, spu_ldxa_illgl_va}),
    .rdy  (lsu_ldxa_rdy),
    .vld  (spu_lsu_ldxa_vld_w2),
    .full (spu_ldxa_full),
    .dout (ldxa_head)
  );

  assign {spu_lsu_ldxa_data_w2, spu_lsu_ldxa_tid_w2, spu_lsu_ldxa_illgl_va_w2} = ldxa_head;

  logic [DATA_W-1:0] rs3_data_reg [RS3_STAGES];
  logic              rs3_vld_reg  [RS3_STAGES];
  logic [DATA_W-1:0] rs3_d_in     [RS3_STAGES];
  logic              rs3_v_in     [RS3_STAGES];

  // Flush kills everything still in flight; the sample moving into the output
  // stage on the flush edge is already committed and is not killed.
  genvar gi;
  generate
    for (gi = 0; gi < RS3_STAGES; gi++) begin : g_rs3
      localparam bit COMMIT = (gi == RS3_STAGES - 1) && (gi != 0);
      if (gi == 0) begin : g_first
        assign rs3_d_in[gi] = exu_rs3_data_e;
        assign rs3_v_in[gi] = exu_rs3_vld_e;
      end else begin : g_next
        assign rs3_d_in[gi] = rs3_data_reg[gi-1];
        assign rs3_v_in[gi] = rs3_vld_reg[gi-1];
      end
      always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
          rs3_data_reg[gi] <= '0;
          rs3_vld_reg[gi]  <= 1'b0;
        end else begin
          rs3_data_reg[gi] <= rs3_d_in[gi];
          rs3_vld_reg[gi]  <= rs3_v_in[gi] & (COMMIT | ~spu_rs3_flush);
        end
      end
    end
  endgenerate

  assign spu_lsurpt_rs3_data = rs3_data_reg[RS3_STAGES-1];
  assign spu_lsurpt_rs3_vld  = rs3_vld_reg[RS3_STAGES-1];

endmodule
